// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-lite control FSM sequencing PC/IR/GRF/EXT/ALU/DM.
// Latency: 2-5 cycles per instruction by class, plus one per mem_ready=0 cycle in MEMRD/MEMWR.
// Backpressure: stalls in MEMRD/MEMWR until mem_ready=1; no other stall source.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        ext_op,
  output logic        mem_we,
  output logic        mem_re,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_MEMWR  = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  logic [2:0]  state_q, state_d;
  logic [31:0] retire_q, retire_d;

  logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;

  // Instruction class decode; funct only matters for R-type.
  always_comb begin
    is_addu = (op == OP_RTYPE) && (funct == FN_ADDU);
    is_subu = (op == OP_RTYPE) && (funct == FN_SUBU);
    is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
    is_ori  = (op == OP_ORI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_lui  = (op == OP_LUI);
    is_jal  = (op == OP_JAL);
  end

  // Next-state selection; unknown encodings and illegal codes fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_addu || is_subu || is_ori || is_lw || is_sw || is_beq || is_jr)
          state_d = S_EXE;
        else if (is_lui || is_jal)
          state_d = S_WB;
        else
          state_d = S_FETCH;
      end
      S_EXE: begin
        if (is_lw)      state_d = S_MEMRD;
        else if (is_sw) state_d = S_MEMWR;
        else if (is_addu || is_subu || is_ori) state_d = S_WB;
        else            state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_WB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Every entry into FETCH retires (or abandons) one instruction.
  always_comb begin
    retire_d = retire_q + {31'd0, (state_d == S_FETCH)};
  end

  // State register and retire counter; reset aborts the current instruction uncounted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      retire_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
    end
  end

  // Moore-per-state control outputs; held at zero while reset is asserted.
  always_comb begin
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (reset) begin
      // ALU setup is shared by EXE and the memory phases that depend on the address.
      if (state_q == S_EXE || state_q == S_MEMRD || state_q == S_MEMWR) begin
        if (is_subu || is_beq) begin
          alu_op = ALU_SUB;
        end else if (is_ori) begin
          alu_op  = ALU_OR;
          alu_src = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end
      end
      case (state_q)
        S_FETCH: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        S_EXE: begin
          if (is_beq) begin
            pc_we  = zero;
            pc_sel = 2'd1;
          end else if (is_jr) begin
            pc_we  = 1'b1;
            pc_sel = 2'd3;
          end
        end
        S_MEMRD: mem_re = 1'b1;
        S_MEMWR: mem_we = mem_ready;
        S_WB: begin
          reg_we = 1'b1;
          if (is_addu || is_subu) begin
            reg_dst = 2'd1;
          end else if (is_lw) begin
            mem_to_reg = 2'd1;
          end else if (is_lui) begin
            mem_to_reg = 2'd2;
          end else if (is_jal) begin
            reg_dst    = 2'd2;
            mem_to_reg = 2'd3;
            pc_we      = 1'b1;
            pc_sel     = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed and random instruction streams against a per-instruction model.
// Each instruction is expanded into its expected phase list; outputs are checked mid-cycle.
// Memory stalls are injected per instruction; reset abort and counter wrap are exercised.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = 6'h00;
  logic [5:0]  funct = 6'h21;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_we, ir_we, reg_we, alu_src, ext_op, mem_we, mem_re;
  logic [1:0]  pc_sel, reg_dst, mem_to_reg;
  logic [2:0]  alu_op, state;
  logic [31:0] retire_cnt;
  logic [15:0] ctrl_vec;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 32'd0;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_LUI = 7, K_JAL = 8, K_UNK = 9;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
    .mem_we(mem_we), .mem_re(mem_re), .state(state), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_we, pc_sel, ir_we, reg_we, reg_dst, mem_to_reg,
                     alu_src, alu_op, ext_op, mem_we, mem_re};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control word for one phase of an instruction of class k.
  function automatic logic [15:0] exp_ctrl(input int k, input int ph, input logic z, input logic mr);
    logic       pcw, irw, rw, src, ext, mw, mre;
    logic [1:0] pcs, dst, mtr;
    logic [2:0] aop;
    logic       a_src, a_ext;
    logic [2:0] a_op;
    pcw = 0; irw = 0; rw = 0; src = 0; ext = 0; mw = 0; mre = 0;
    pcs = 0; dst = 0; mtr = 0; aop = 0;
    a_src = 0; a_ext = 0; a_op = 0;
    case (k)
      K_SUBU, K_BEQ: a_op = 3'd1;
      K_ORI:         begin a_op = 3'd2; a_src = 1; end
      K_LW, K_SW:    begin a_src = 1; a_ext = 1; end
      default: ;
    endcase
    case (ph)
      0: begin pcw = 1; irw = 1; end
      2: begin
        aop = a_op; src = a_src; ext = a_ext;
        if (k == K_BEQ) begin pcw = z; pcs = 2'd1; end
        if (k == K_JR)  begin pcw = 1; pcs = 2'd3; end
      end
      3: begin aop = a_op; src = a_src; ext = a_ext; mre = 1; end
      4: begin aop = a_op; src = a_src; ext = a_ext; mw = mr; end
      5: begin
        rw = 1;
        if (k == K_ADDU || k == K_SUBU) dst = 2'd1;
        if (k == K_LW)  mtr = 2'd1;
        if (k == K_LUI) mtr = 2'd2;
        if (k == K_JAL) begin dst = 2'd2; mtr = 2'd3; pcw = 1; pcs = 2'd2; end
      end
      default: ;
    endcase
    return {pcw, pcs, irw, rw, dst, mtr, src, aop, ext, mw, mre};
  endfunction

  // Legal encodings; I-type funct is randomised since it must be ignored.
  task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU: begin o = 6'h00; f = 6'h21; end
      K_SUBU: begin o = 6'h00; f = 6'h23; end
      K_JR:   begin o = 6'h00; f = 6'h08; end
      K_ORI:  o = 6'h0d;
      K_LW:   o = 6'h23;
      K_SW:   o = 6'h2b;
      K_BEQ:  o = 6'h04;
      K_LUI:  o = 6'h0f;
      K_JAL:  o = 6'h03;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (o == 6'h0d || o == 6'h23 || o == 6'h2b || o == 6'h04 || o == 6'h0f || o == 6'h03)
          o = 6'($urandom_range(0, 63));
        if (o == 6'h00)
          while (f == 6'h21 || f == 6'h23 || f == 6'h08) f = 6'($urandom_range(0, 63));
      end
    endcase
  endtask

  // Runs one instruction from its FETCH cycle; ends at the next FETCH negedge.
  task automatic run_instr(input int k, input logic [5:0] o, input logic [5:0] f,
                           input int stalls, input logic z, input bit preload);
    int path[$];
    int mem_idx;
    logic mr;
    path.push_back(0);
    path.push_back(1);
    case (k)
      K_BEQ, K_JR:           path.push_back(2);
      K_LUI, K_JAL:          path.push_back(5);
      K_ADDU, K_SUBU, K_ORI: begin path.push_back(2); path.push_back(5); end
      K_SW: begin
        path.push_back(2);
        for (int s = 0; s <= stalls; s++) path.push_back(4);
      end
      K_LW: begin
        path.push_back(2);
        for (int s = 0; s <= stalls; s++) path.push_back(3);
        path.push_back(5);
      end
      default: ;
    endcase
    op = o;
    funct = f;
    mem_idx = 0;
    for (int i = 0; i < path.size(); i++) begin
      if (path[i] == 3 || path[i] == 4) begin
        mr = (mem_idx < stalls) ? 1'b0 : 1'b1;
        mem_idx++;
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      mem_ready = mr;
      zero = z;
      if (preload && i == 0) begin
        force dut.retire_q = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
      end
      if (preload && i == 1) release dut.retire_q;
      #1;
      chk("state", {29'd0, state}, path[i]);
      chk("ctrl", {16'd0, ctrl_vec}, {16'd0, exp_ctrl(k, path[i], z, mr)});
      chk("retire_cnt", retire_cnt, exp_cnt);
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic run_kind(input int k, input int stalls, input logic z);
    logic [5:0] o, f;
    encode(k, o, f);
    run_instr(k, o, f, stalls, z, 1'b0);
  endtask

  initial begin
    logic [5:0] o, f;
    int k;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_ctrl", {16'd0, ctrl_vec}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed instruction walk
    run_instr(K_ADDU, 6'h00, 6'h21, 0, 1'b0, 1'b0);
    chk("cnt_after_addu", retire_cnt, 32'd1);
    run_kind(K_LW, 3, 1'b0);
    run_kind(K_BEQ, 0, 1'b1);
    run_kind(K_BEQ, 0, 1'b0);
    run_kind(K_JAL, 0, 1'b0);
    run_instr(K_UNK, 6'h3f, 6'h00, 0, 1'b0, 1'b0);
    run_instr(K_UNK, 6'h00, 6'h00, 0, 1'b0, 1'b0);
    run_kind(K_LUI, 0, 1'b0);
    run_kind(K_JR, 0, 1'b0);
    run_kind(K_SW, 2, 1'b0);
    run_kind(K_ORI, 0, 1'b1);
    run_kind(K_SUBU, 1, 1'b0);

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      encode(k, o, f);
      run_instr(k, o, f, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset during MEMWR of sw
    op = 6'h2b;
    funct = 6'h00;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_pre_state", {29'd0, state}, 32'd4);
    chk("abort_pre_mem_we", {31'd0, mem_we}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_ctrl", {16'd0, ctrl_vec}, 32'd0);
    chk("abort_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 32'd0;
    run_kind(K_ORI, 0, 1'b0);
    chk("cnt_after_abort", retire_cnt, 32'd1);

    // Counter wrap
    run_instr(K_ADDU, 6'h00, 6'h21, 0, 1'b0, 1'b1);
    chk("wrap_ffffffff", retire_cnt, 32'hFFFF_FFFF);
    run_kind(K_BEQ, 0, 1'b1);
    chk("wrap_zero", retire_cnt, 32'd0);
    run_kind(K_ADDU, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-lite core: a state machine that sequences a shared datapath (PC, IR, GRF, EXT, ALU, DM) over several clock cycles per instruction, replacing the single-cycle combinational controller. It decodes the latched instruction's opcode and funct fields and drives every write enable and mux select, one phase at a time. It also stalls on the data-memory ready handshake and counts retired instructions.

## Interface
Parameters:
- none (instruction encodings fixed: R-type op 6'h00 with funct addu 6'h21, subu 6'h23, jr 6'h08; ori 6'h0d, lw 6'h23, sw 6'h2b, beq 6'h04, lui 6'h0f, jal 6'h03)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- op  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  DM access complete this cycle
- pc_we  out  1  PC register write enable
- pc_sel  out  2  0 PC+4, 1 branch target, 2 jal target {PC[31:28],imm26,2'b0}, 3 GPR[rs]
- ir_we  out  1  IR write enable
- reg_we  out  1  GRF write enable
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- mem_to_reg  out  2  0 ALU result, 1 DM data, 2 {imm16,16'b0}, 3 PC+4
- alu_src  out  1  0 GPR[rt], 1 EXT output
- alu_op  out  3  0 add, 1 sub, 2 or
- ext_op  out  1  0 zero-extend, 1 sign-extend
- mem_we  out  1  DM write enable
- mem_re  out  1  DM read request
- state  out  3  current FSM state
- retire_cnt  out  32  instructions retired since reset

## Operation
- States: FETCH=0, DECODE=1, EXE=2, MEMRD=3, MEMWR=4, WB=5; codes 6,7 are illegal and go to FETCH.
- FETCH: ir_we=1, pc_we=1, pc_sel=0. Always goes to DECODE.
- DECODE: no write enables. Next state by class:
  - addu/subu/ori/lw/sw/beq/jr → EXE
  - lui/jal → WB
  - any other encoding, including nop (op=0, funct=0) → FETCH; this retires the instruction.
- EXE: alu_op/alu_src/ext_op per class: addu add/0; subu sub/0; ori or/1/zero-ext; lw/sw add/1/sign-ext; beq sub/0.
  - addu/subu/ori → WB.
  - lw → MEMRD; sw → MEMWR.
  - beq: pc_we=zero, pc_sel=1 → FETCH.
  - jr: pc_we=1, pc_sel=3 → FETCH.
- MEMRD: mem_re=1, ALU controls held as in EXE. Stays in MEMRD while mem_ready=0; goes to WB when mem_ready=1.
- MEMWR: mem_we=1 only while mem_ready=1, ALU controls held. Goes to FETCH on mem_ready=1.
- WB: reg_we=1 → FETCH. Selects per class:
  - addu/subu: reg_dst=1, mem_to_reg=0
  - ori: reg_dst=0, mem_to_reg=0
  - lw: reg_dst=0, mem_to_reg=1
  - lui: reg_dst=0, mem_to_reg=2
  - jal: reg_dst=2, mem_to_reg=3, plus pc_we=1, pc_sel=2.
- PC+4 is the value latched in FETCH; the datapath holds it and exposes it during later states.
- Control outputs are combinational from state plus op/funct (Moore per state). Any output not listed for a state is 0.
- retire_cnt increments by 1 on every transition into FETCH, except the transition out of reset. It wraps from 32'hFFFFFFFF to 0.

## Timing
- While reset=0: state=FETCH; retire_cnt=0; every write enable (pc_we, ir_we, reg_we, mem_we) and mem_re is forced to 0; selects are 0.
- Reset asserted mid-instruction aborts it immediately; the aborted instruction is not counted.
- First FETCH edge occurs on the first rising clk after reset deasserts.
- Cycles per instruction, with mem_ready=1:
  - nop/unknown: 2
  - beq, jr, lui, jal: 3
  - addu, subu, ori, sw: 4
  - lw: 5
- Each cycle of mem_ready=0 in MEMRD or MEMWR adds one cycle.
- State register and retire_cnt update on the rising clk edge.

## Test plan
- Reset release, op=6'h00, funct=6'h21: state sequence 0,1,2,5,0. reg_we=1 only in state 5, with reg_dst=1. retire_cnt goes 0→1 on return to FETCH.
- lw (op 6'h23) with mem_ready held 0 for 3 cycles, then 1: state sequence 0,1,2,3,3,3,3,5,0. mem_re=1 in all four MEMRD cycles. reg_we=1 with mem_to_reg=1 in WB.
- beq (op 6'h04): with zero=1, pc_we=1 and pc_sel=1 in EXE; with zero=0, pc_we=0 in EXE. Both cases take 3 cycles.
- jal (op 6'h03): state sequence 0,1,5,0. In WB: reg_we=1, reg_dst=2, mem_to_reg=3, pc_we=1, pc_sel=2.
- Unknown op 6'h3f: state sequence 0,1,0, with no write enables in DECODE and retire_cnt +1. Drive reset=0 asynchronously during MEMWR of an sw: state=0 and mem_we=0 immediately, and retire_cnt=0.
- retire_cnt wrap: execute 2 instructions after retire_cnt reaches 32'hFFFFFFFE; it must read 32'hFFFFFFFF, then 0.
